// File: rtl/ddr3_phy_pkg.sv
// ddr3_phy_pkg
// Shared definitions for the DDR3 lane delay-line sequencer: FSM state
// encoding, line-select / direction encodings, tap width and the range
// check used before every delay-line move.
package ddr3_phy_pkg;

   localparam int TAP_W = 8;

   localparam logic SEL_RX  = 1'b0;
   localparam logic SEL_TX  = 1'b1;
   localparam logic DIR_INC = 1'b1;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_SETUP,
      ST_PULSE,
      ST_GAP,
      ST_DONE
   } seq_state_e;

   // True when one more step in direction dir would leave [0, tap_max].
   function automatic logic tap_blocked(input logic [TAP_W-1:0] tap,
                                        input logic             dir,
                                        input logic [TAP_W-1:0] tap_max);
      return (dir == DIR_INC) ? (tap == tap_max) : (tap == '0);
   endfunction

endpackage

// File: rtl/ddr3_lane_dly_sequencer_if.sv
// ddr3_lane_dly_sequencer_if
// Request/completion channel between the training logic and the sequencer.
//   REQ_VALID/REQ_READY : request handshake
//   REQ_SEL/LOAD/DIR/STEPS : request payload
//   DONE/ERR            : one-cycle completion pulse and abort flag
// master = training side, slave = sequencer.
interface ddr3_lane_dly_sequencer_if;
   import ddr3_phy_pkg::*;

   logic             REQ_VALID;
   logic             REQ_READY;
   logic             REQ_SEL;
   logic             REQ_LOAD;
   logic             REQ_DIR;
   logic [TAP_W-1:0] REQ_STEPS;
   logic             DONE;
   logic             ERR;

   modport master (
      output REQ_VALID, REQ_SEL, REQ_LOAD, REQ_DIR, REQ_STEPS,
      input  REQ_READY, DONE, ERR
   );

   modport slave (
      input  REQ_VALID, REQ_SEL, REQ_LOAD, REQ_DIR, REQ_STEPS,
      output REQ_READY, DONE, ERR
   );

endinterface

// File: rtl/ddr3_lane_dly_sequencer.sv
// ddr3_lane_dly_sequencer
// Turns "move N taps" / "reload" requests into single-cycle MOVE/LOAD
// pulses on one lane's DQS delay-line control port, spaced MOVE_GAP cycles
// apart, while tracking the RX and TX tap positions.
// Ports:
//   FAB_CLK, RESET        : fabric clock, async active-high reset
//   req (slave)           : request handshake, DONE/ERR completion
//   RX_TAP, TX_TAP        : tracked tap positions
//   DELAY_LINE_*          : control to the lane controller
//   *_OUT_OF_RANGE        : lane-reported range flags, sampled at the end
//                           of each post-pulse gap
module ddr3_lane_dly_sequencer
   import ddr3_phy_pkg::*;
#(
   parameter int               MOVE_GAP = 4,
   parameter logic [TAP_W-1:0] INIT_TAP = 8'd1,
   parameter logic [TAP_W-1:0] TAP_MAX  = 8'd255
) (
   input  logic                  FAB_CLK,
   input  logic                  RESET,
   ddr3_lane_dly_sequencer_if.slave req,
   output logic [TAP_W-1:0]      RX_TAP,
   output logic [TAP_W-1:0]      TX_TAP,
   output logic                  DELAY_LINE_SEL,
   output logic                  DELAY_LINE_LOAD,
   output logic                  DELAY_LINE_DIRECTION,
   output logic                  DELAY_LINE_MOVE,
   input  logic                  RX_DELAY_LINE_OUT_OF_RANGE,
   input  logic                  TX_DELAY_LINE_OUT_OF_RANGE
);

   localparam int GAP_W = (MOVE_GAP > 2) ? $clog2(MOVE_GAP) : 1;
   // Gap counter reloads so that GAP lasts MOVE_GAP-1 cycles, ending at 0.
   localparam logic [GAP_W-1:0] GAP_LOAD = GAP_W'(MOVE_GAP - 2);

   seq_state_e       state_q, state_d;
   logic             sel_q, sel_d;
   logic             load_q, load_d;
   logic             dir_q, dir_d;
   logic             err_q, err_d;
   logic [TAP_W-1:0] rem_q, rem_d;
   logic [GAP_W-1:0] gap_q, gap_d;
   logic [TAP_W-1:0] rx_tap_q, rx_tap_d;
   logic [TAP_W-1:0] tx_tap_q, tx_tap_d;

   logic [TAP_W-1:0] cur_tap;
   logic             cur_oor;

   assign cur_tap = (sel_q == SEL_TX) ? tx_tap_q : rx_tap_q;
   assign cur_oor = (sel_q == SEL_TX) ? TX_DELAY_LINE_OUT_OF_RANGE
                                      : RX_DELAY_LINE_OUT_OF_RANGE;

   always_ff @(posedge FAB_CLK or posedge RESET) begin
      if (RESET) begin
         state_q  <= ST_IDLE;
         sel_q    <= 1'b0;
         load_q   <= 1'b0;
         dir_q    <= 1'b0;
         err_q    <= 1'b0;
         rem_q    <= '0;
         gap_q    <= '0;
         rx_tap_q <= INIT_TAP;
         tx_tap_q <= INIT_TAP;
      end else begin
         state_q  <= state_d;
         sel_q    <= sel_d;
         load_q   <= load_d;
         dir_q    <= dir_d;
         err_q    <= err_d;
         rem_q    <= rem_d;
         gap_q    <= gap_d;
         rx_tap_q <= rx_tap_d;
         tx_tap_q <= tx_tap_d;
      end
   end

   always_comb begin
      state_d  = state_q;
      sel_d    = sel_q;
      load_d   = load_q;
      dir_d    = dir_q;
      err_d    = err_q;
      rem_d    = rem_q;
      gap_d    = gap_q;
      rx_tap_d = rx_tap_q;
      tx_tap_d = tx_tap_q;

      case (state_q)
         ST_IDLE: begin
            if (req.REQ_VALID) begin
               sel_d   = req.REQ_SEL;
               load_d  = req.REQ_LOAD;
               // Direction is meaningless for a reload; keep the pin quiet.
               dir_d   = req.REQ_DIR & ~req.REQ_LOAD;
               rem_d   = req.REQ_STEPS;
               err_d   = 1'b0;
               state_d = ST_SETUP;
            end
         end

         ST_SETUP: begin
            if (!load_q && rem_q == '0) begin
               err_d   = 1'b0;
               state_d = ST_DONE;
            end else if (!load_q && tap_blocked(cur_tap, dir_q, TAP_MAX)) begin
               err_d   = 1'b1;
               state_d = ST_DONE;
            end else begin
               state_d = ST_PULSE;
            end
         end

         ST_PULSE: begin
            gap_d   = GAP_LOAD;
            state_d = ST_GAP;
            if (load_q) begin
               if (sel_q == SEL_TX) tx_tap_d = INIT_TAP;
               else                 rx_tap_d = INIT_TAP;
            end else begin
               // Range checks before every pulse keep this from wrapping.
               if (sel_q == SEL_TX)
                  tx_tap_d = (dir_q == DIR_INC) ? tx_tap_q + 8'd1 : tx_tap_q - 8'd1;
               else
                  rx_tap_d = (dir_q == DIR_INC) ? rx_tap_q + 8'd1 : rx_tap_q - 8'd1;
               rem_d = rem_q - 8'd1;
            end
         end

         ST_GAP: begin
            if (gap_q != '0) begin
               gap_d = gap_q - 1'b1;
            end else if (cur_oor) begin
               err_d   = 1'b1;
               state_d = ST_DONE;
            end else if (load_q || rem_q == '0) begin
               err_d   = 1'b0;
               state_d = ST_DONE;
            end else if (tap_blocked(cur_tap, dir_q, TAP_MAX)) begin
               err_d   = 1'b1;
               state_d = ST_DONE;
            end else begin
               state_d = ST_PULSE;
            end
         end

         ST_DONE: begin
            // Release SEL/DIRECTION so the lane sees them low while idle.
            sel_d   = 1'b0;
            dir_d   = 1'b0;
            load_d  = 1'b0;
            state_d = ST_IDLE;
         end

         default: state_d = ST_IDLE;
      endcase
   end

   assign req.REQ_READY        = (state_q == ST_IDLE);
   assign req.DONE             = (state_q == ST_DONE);
   assign req.ERR              = (state_q == ST_DONE) & err_q;
   assign DELAY_LINE_SEL       = (state_q != ST_IDLE) & sel_q;
   assign DELAY_LINE_DIRECTION = (state_q != ST_IDLE) & dir_q;
   assign DELAY_LINE_LOAD      = (state_q == ST_PULSE) &  load_q;
   assign DELAY_LINE_MOVE      = (state_q == ST_PULSE) & ~load_q;
   assign RX_TAP               = rx_tap_q;
   assign TX_TAP               = tx_tap_q;

endmodule

// File: tb/tb_ddr3_lane_dly_sequencer.sv
// Directed bench for ddr3_lane_dly_sequencer (MOVE_GAP=4, INIT_TAP=1,
// TAP_MAX=12 so the upper range limit is reachable in a few steps).
module tb_ddr3_lane_dly_sequencer;
   import ddr3_phy_pkg::*;

   localparam int G    = 4;
   localparam int MAXC = 200;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic [7:0] rx_tap, tx_tap;
   logic       dl_sel, dl_load, dl_dir, dl_move;
   logic       rx_oor = 1'b0, tx_oor = 1'b0;

   int n_vec = 0;
   int n_bad = 0;

   ddr3_lane_dly_sequencer_if rq();

   ddr3_lane_dly_sequencer #(
      .MOVE_GAP (G),
      .INIT_TAP (8'd1),
      .TAP_MAX  (8'd12)
   ) dut (
      .FAB_CLK                    (clk),
      .RESET                      (rst),
      .req                        (rq.slave),
      .RX_TAP                     (rx_tap),
      .TX_TAP                     (tx_tap),
      .DELAY_LINE_SEL             (dl_sel),
      .DELAY_LINE_LOAD            (dl_load),
      .DELAY_LINE_DIRECTION       (dl_dir),
      .DELAY_LINE_MOVE            (dl_move),
      .RX_DELAY_LINE_OUT_OF_RANGE (rx_oor),
      .TX_DELAY_LINE_OUT_OF_RANGE (tx_oor)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic       sel;
      logic       load;
      logic       dir;
      logic [7:0] steps;
      int         oor_after;   // raise selected OOR after this pulse (0 = never)
      logic       oor_other;   // hold the other line's OOR high throughout
      int         exp_pulses;
      int         exp_done;    // cycle of DONE relative to acceptance
      logic       exp_err;
      int         exp_rx;
      int         exp_tx;
   } vec_t;

   vec_t vecs[12];

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string name, input int act, input int exp);
      n_vec++;
      if (act != exp) begin
         n_bad++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   task automatic chk_reset_outs(input string tag);
      chk({tag, " ready"}, int'(rq.REQ_READY), 1);
      chk({tag, " done"},  int'(rq.DONE), 0);
      chk({tag, " err"},   int'(rq.ERR), 0);
      chk({tag, " dl"},    int'({dl_sel, dl_load, dl_dir, dl_move}), 0);
      chk({tag, " rx_tap"}, int'(rx_tap), 1);
      chk({tag, " tx_tap"}, int'(tx_tap), 1);
   endtask

   task automatic run_vec(input vec_t v, input string tag);
      int   np, first, last, donek, errv;
      bit   spacing_ok, stable_ok, kind_ok;
      np = 0; first = -1; last = -1; donek = -1; errv = -1;
      spacing_ok = 1'b1; stable_ok = 1'b1; kind_ok = 1'b1;

      if (v.oor_other) begin
         if (v.sel) rx_oor = 1'b1; else tx_oor = 1'b1;
      end
      rq.REQ_VALID = 1'b1;
      rq.REQ_SEL   = v.sel;
      rq.REQ_LOAD  = v.load;
      rq.REQ_DIR   = v.dir;
      rq.REQ_STEPS = v.steps;
      chk({tag, " ready@t0"}, int'(rq.REQ_READY), 1);
      step();
      rq.REQ_VALID = 1'b0;

      for (int k = 1; k <= MAXC; k++) begin
         if (dl_sel !== v.sel) stable_ok = 1'b0;
         if (!v.load && dl_dir !== v.dir) stable_ok = 1'b0;
         if (rq.REQ_READY) stable_ok = 1'b0;
         if (dl_move && dl_load) kind_ok = 1'b0;
         if (dl_move || dl_load) begin
            if (v.load ? !dl_load : !dl_move) kind_ok = 1'b0;
            if (np == 0) first = k;
            else if (k - last != G) spacing_ok = 1'b0;
            last = k;
            np++;
            if (v.oor_after != 0 && np == v.oor_after) begin
               if (v.sel) tx_oor = 1'b1; else rx_oor = 1'b1;
            end
         end
         if (rq.DONE) begin
            donek = k;
            errv  = int'(rq.ERR);
            break;
         end
         step();
      end

      chk({tag, " pulses"},  np, v.exp_pulses);
      chk({tag, " done_at"}, donek, v.exp_done);
      chk({tag, " err"},     errv, int'(v.exp_err));
      if (v.exp_pulses > 0) begin
         chk({tag, " first_pulse"}, first, 2);
         chk({tag, " spacing"}, int'(spacing_ok), 1);
         chk({tag, " kind"},    int'(kind_ok), 1);
      end
      chk({tag, " sel_dir_stable"}, int'(stable_ok), 1);
      chk({tag, " rx_tap"}, int'(rx_tap), v.exp_rx);
      chk({tag, " tx_tap"}, int'(tx_tap), v.exp_tx);

      step();
      rx_oor = 1'b0;
      tx_oor = 1'b0;
      chk({tag, " idle_ready"}, int'(rq.REQ_READY), 1);
      chk({tag, " idle_released"}, int'({dl_sel, dl_dir, rq.DONE}), 0);
   endtask

   initial begin
      int pulses;
      bit saw_done;

      //            sel load dir steps oor oth  np done err rx  tx
      vecs[0]  = '{1'b0, 1'b0, 1'b1, 8'd3,  0, 1'b0, 3, 14, 1'b0, 4,  1};
      vecs[1]  = '{1'b1, 1'b0, 1'b0, 8'd5,  0, 1'b0, 1,  6, 1'b1, 4,  0};
      vecs[2]  = '{1'b0, 1'b0, 1'b1, 8'd6,  2, 1'b0, 2, 10, 1'b1, 6,  0};
      vecs[3]  = '{1'b1, 1'b0, 1'b1, 8'd10, 0, 1'b1, 10, 42, 1'b0, 6, 10};
      vecs[4]  = '{1'b1, 1'b1, 1'b0, 8'd7,  0, 1'b0, 1,  6, 1'b0, 6,  1};
      vecs[5]  = '{1'b1, 1'b0, 1'b0, 8'd0,  0, 1'b0, 0,  2, 1'b0, 6,  1};
      vecs[6]  = '{1'b1, 1'b0, 1'b0, 8'd1,  0, 1'b0, 1,  6, 1'b0, 6,  0};
      vecs[7]  = '{1'b1, 1'b0, 1'b0, 8'd1,  0, 1'b0, 0,  2, 1'b1, 6,  0};
      vecs[8]  = '{1'b0, 1'b0, 1'b1, 8'd10, 0, 1'b0, 6, 26, 1'b1, 12, 0};
      vecs[9]  = '{1'b0, 1'b0, 1'b1, 8'd1,  0, 1'b0, 0,  2, 1'b1, 12, 0};
      vecs[10] = '{1'b0, 1'b1, 1'b1, 8'd0,  0, 1'b0, 1,  6, 1'b0, 1,  0};
      vecs[11] = '{1'b1, 1'b0, 1'b1, 8'd4,  1, 1'b0, 1,  6, 1'b1, 1,  1};

      rq.REQ_VALID = 1'b0;
      rq.REQ_SEL   = 1'b0;
      rq.REQ_LOAD  = 1'b0;
      rq.REQ_DIR   = 1'b0;
      rq.REQ_STEPS = 8'd0;

      repeat (3) step();
      chk_reset_outs("reset");
      rst = 1'b0;
      step();
      chk_reset_outs("post_reset");

      // Zero-step request with REQ_VALID held: DONE at t0+2, re-accept at t0+3.
      pulses = 0;
      rq.REQ_VALID = 1'b1;
      rq.REQ_DIR   = 1'b1;
      rq.REQ_STEPS = 8'd0;
      step();                                        // t0+1
      pulses += int'(dl_move | dl_load);
      chk("b2b ready@1", int'(rq.REQ_READY), 0);
      chk("b2b done@1",  int'(rq.DONE), 0);
      step();                                        // t0+2
      pulses += int'(dl_move | dl_load);
      chk("b2b done@2",  int'(rq.DONE), 1);
      chk("b2b err@2",   int'(rq.ERR), 0);
      chk("b2b ready@2", int'(rq.REQ_READY), 0);
      step();                                        // t0+3: accepted again
      chk("b2b ready@3", int'(rq.REQ_READY), 1);
      step();                                        // second SETUP
      rq.REQ_VALID = 1'b0;
      pulses += int'(dl_move | dl_load);
      chk("b2b ready@4", int'(rq.REQ_READY), 0);
      step();
      chk("b2b done@5", int'(rq.DONE), 1);
      chk("b2b no_pulses", pulses, 0);
      step();

      for (int i = 0; i < 12; i++)
         run_vec(vecs[i], $sformatf("vec%0d", i));

      // Reset in the middle of a GAP: outputs drop at once, no DONE later.
      rq.REQ_VALID = 1'b1;
      rq.REQ_SEL   = 1'b0;
      rq.REQ_LOAD  = 1'b0;
      rq.REQ_DIR   = 1'b1;
      rq.REQ_STEPS = 8'd3;
      step();
      rq.REQ_VALID = 1'b0;
      step();                                        // PULSE
      step();                                        // GAP, RX_TAP = 2
      chk("midgap rx_tap", int'(rx_tap), 2);
      rst = 1'b1;
      #1;
      chk_reset_outs("midgap_reset");
      step();
      rst = 1'b0;
      saw_done = 1'b0;
      for (int k = 0; k < 20; k++) begin
         if (rq.DONE) saw_done = 1'b1;
         step();
      end
      chk("midgap no_done", int'(saw_done), 0);

      run_vec('{1'b0, 1'b0, 1'b1, 8'd2, 0, 1'b0, 2, 10, 1'b0, 3, 1}, "after_reset");

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

endmodule
